// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch memory.
// Optional load port is enabled with IM_LOAD_PORT_EN.
`timescale 1ns/1ps
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int ERR_MISALIGN = 0;
   localparam int ERR_RANGE    = 1;
   localparam int LATENCY_MIN  = 1;
   localparam int LATENCY_MAX  = 4;

   // Whole word a..a+3 lies inside storage; 33-bit sum so no wrap.
   function automatic logic word_in_range(
      input logic [31:0] a,
      input int unsigned nbytes
   );
      return ({1'b0, a} + 33'd3) < 33'(nbytes);
   endfunction

endpackage

// File: rtl/im_byte_array.sv
// Byte-wide instruction storage: big-endian 4-byte combinational read,
// synchronous word write (tied off unless IM_LOAD_PORT_EN is defined).
`timescale 1ns/1ps
module im_byte_array
   import instr_fetch_pkg::*;
#(
   parameter int MEM_BYTES = 128
) (
   input  logic        clk,
   input  logic [31:0] i_rd_addr,
   output logic [31:0] o_rd_data,
   input  logic        i_wr_en,
   input  logic [31:0] i_wr_addr,
   input  logic [31:0] i_wr_data
);

   localparam int AW = $clog2(MEM_BYTES);

   logic [7:0]    r_mem [MEM_BYTES];
   logic [AW-1:0] w_rd_base;
   logic [AW-1:0] w_wr_base;
   logic          w_rd_ok;
   logic          w_wr_ok;

   assign w_rd_base = i_rd_addr[AW-1:0];
   assign w_wr_base = i_wr_addr[AW-1:0];
   assign w_rd_ok   = word_in_range(i_rd_addr, MEM_BYTES);
   assign w_wr_ok   = word_in_range(i_wr_addr, MEM_BYTES)
                    & (i_wr_addr[1:0] == 2'b00);

   always_comb begin
      o_rd_data = '0;
      if (w_rd_ok) begin
         o_rd_data = {r_mem[w_rd_base],
                      r_mem[w_rd_base + AW'(1)],
                      r_mem[w_rd_base + AW'(2)],
                      r_mem[w_rd_base + AW'(3)]};
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (i_wr_en && w_wr_ok) begin
         r_mem[w_wr_base]          <= i_wr_data[31:24];
         r_mem[w_wr_base + AW'(1)] <= i_wr_data[23:16];
         r_mem[w_wr_base + AW'(2)] <= i_wr_data[15:8];
         r_mem[w_wr_base + AW'(3)] <= i_wr_data[7:0];
      end
   end

endmodule

// File: rtl/instr_fetch_mem.sv
// Fixed-latency instruction fetch memory with flush and error flags.
// Define IM_LOAD_PORT_EN to add the load_valid/load_addr/load_data port.
`timescale 1ns/1ps
module instr_fetch_mem
   import instr_fetch_pkg::*;
#(
   parameter int MEM_BYTES = 128,
   parameter int LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        flush,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_instr,
   output logic [1:0]  rsp_err
`ifdef IM_LOAD_PORT_EN
   ,
   input  logic        load_valid,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data
`endif
);

   localparam int LAT = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                        (LATENCY > LATENCY_MAX) ? LATENCY_MAX :
                        LATENCY;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [2:0]  r_cnt;
   logic [2:0]  w_cnt_nxt;
   logic [31:0] r_addr;
   logic [31:0] r_instr;
   logic [1:0]  r_err;
   logic        w_accept;
   logic        w_sample;
   logic        w_load;
   logic [31:0] w_ld_addr;
   logic [31:0] w_ld_data;
   logic [31:0] w_rd_addr;
   logic [31:0] w_rd_data;
   logic [1:0]  w_err;

`ifdef IM_LOAD_PORT_EN
   assign w_load    = load_valid;
   assign w_ld_addr = load_addr;
   assign w_ld_data = load_data;
`else
   assign w_load    = 1'b0;
   assign w_ld_addr = '0;
   assign w_ld_data = '0;
`endif

   assign req_ready = rst_n & (r_state == IDLE) & ~flush & ~w_load;
   assign w_accept  = req_valid & req_ready;
   assign rsp_valid = (r_state == RESP);
   assign rsp_instr = r_instr;
   assign rsp_err   = r_err;

   // With LAT=1 the sample happens on the accept edge, before r_addr holds it.
   assign w_rd_addr = (r_state == IDLE) ? req_addr : r_addr;

   assign w_err[ERR_MISALIGN] = |w_rd_addr[1:0];
   assign w_err[ERR_RANGE]    = ~word_in_range(w_rd_addr, MEM_BYTES);

   im_byte_array #(
      .MEM_BYTES (MEM_BYTES)
   ) u_mem (
      .clk       (clk),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data),
      .i_wr_en   (w_load),
      .i_wr_addr (w_ld_addr),
      .i_wr_data (w_ld_data)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_sample    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (LAT == 1) begin
                  w_state_nxt = RESP;
                  w_cnt_nxt   = 3'd0;
                  w_sample    = 1'b1;
               end else begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = 3'(LAT - 1);
               end
            end
         end
         WAIT: begin
            if (flush) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = 3'd0;
            end else if (r_cnt <= 3'd1) begin
               w_state_nxt = RESP;
               w_cnt_nxt   = 3'd0;
               w_sample    = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt - 3'd1;
            end
         end
         RESP: begin
            if (rsp_ready || flush) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= 3'd0;
         r_addr  <= '0;
         r_instr <= '0;
         r_err   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_addr <= req_addr;
         end
         if (w_sample) begin
            r_instr <= (|w_err) ? 32'd0 : w_rd_data;
            r_err   <= w_err;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: driver pushes expected responses,
// an independent monitor compares them when the DUT presents rsp_valid.
`timescale 1ns/1ps
module tb_instr_fetch_mem;

   localparam int MB  = 128;
   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = '0;
   logic        flush = 1'b0;
   logic        rsp_ready = 1'b0;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_instr;
   logic [1:0]  rsp_err;
`ifdef IM_LOAD_PORT_EN
   logic        load_valid = 1'b0;
   logic [31:0] load_addr = '0;
   logic [31:0] load_data = '0;
`endif

   instr_fetch_mem #(
      .MEM_BYTES (MB),
      .LATENCY   (LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .flush     (flush),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_instr (rsp_instr),
      .rsp_err   (rsp_err)
`ifdef IM_LOAD_PORT_EN
      ,
      .load_valid (load_valid),
      .load_addr  (load_addr),
      .load_data  (load_data)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [1:0]  err;
      int          rise;
   } exp_t;

   exp_t       q[$];
   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   logic [7:0] mm [MB];
   bit         prev_v = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: big-endian word, error bits from plain address arithmetic.
   function automatic exp_t model(input logic [31:0] a);
      exp_t m;
      longint unsigned ea;
      int base;
      ea = longint'({32'd0, a});
      m.err[0] = (a % 4) != 0;
      m.err[1] = (ea + 3) >= MB;
      m.instr = '0;
      m.rise = 0;
      if (m.err == 2'b00) begin
         base = int'(a);
         m.instr = {mm[base], mm[base+1], mm[base+2], mm[base+3]};
      end
      return m;
   endfunction

   always @(negedge clk) begin
      if (rsp_valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got %h expected none", rsp_instr);
         end else begin
            if (!prev_v) chk("rise_cycle", cyc, q[0].rise);
            chk("rsp_instr", rsp_instr, q[0].instr);
            chk("rsp_err", {30'd0, rsp_err}, {30'd0, q[0].err});
            if (rsp_ready) void'(q.pop_front());
         end
      end
      prev_v = rsp_valid;
   end

   task automatic issue(input logic [31:0] a);
      exp_t e;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_addr  = a;
      @(negedge clk);
      chk("req_ready_idle", req_ready, 1);
      e = model(a);
      e.rise = cyc + LAT;
      if (req_ready) q.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic complete(input int stall);
      int t;
      t = 0;
      while (!rsp_valid && t < 10) begin
         @(negedge clk);
         t++;
      end
      if (!rsp_valid) begin
         checks++;
         errors++;
         $display("FAIL rsp_timeout: got no rsp_valid expected one");
         if (q.size() > 0) void'(q.pop_back());
         return;
      end
      repeat (stall) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1);
         chk("ready_in_resp", req_ready, 0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("valid_drop", rsp_valid, 0);
      chk("ready_back", req_ready, 1);
   endtask

   task automatic flush_after(input int k);
      repeat (k) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      if (q.size() > 0) void'(q.pop_back());
      @(negedge clk);
      chk("flush_valid", rsp_valid, 0);
      chk("flush_ready", req_ready, 1);
   endtask

`ifdef IM_LOAD_PORT_EN
   task automatic load(input logic [31:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      load_valid = 1'b1;
      load_addr  = a;
      load_data  = d;
      @(posedge clk); #1;
      load_valid = 1'b0;
   endtask
`endif

   initial begin
      int t;
      logic [31:0] a;
      for (int i = 0; i < MB; i++) mm[i] = 8'($urandom);
      mm[0] = 8'h8C;
      mm[1] = 8'h01;
      mm[2] = 8'h00;
      mm[3] = 8'h04;
`ifdef IM_LOAD_PORT_EN
      for (int i = 0; i < MB; i += 4)
         load(32'(i), {mm[i], mm[i+1], mm[i+2], mm[i+3]});
`else
      for (int i = 0; i < MB; i++) dut.u_mem.r_mem[i] = mm[i];
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_instr", rsp_instr, 0);
      chk("rst_err", {30'd0, rsp_err}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      issue(32'h0);        complete(0);
      issue(32'h6);        complete(1);
      issue(32'h7E);       complete(0);
      issue(32'h7C);       complete(2);
      issue(32'h7D);       complete(0);
      issue(32'hFFFFFFFE); complete(0);
      issue(32'hFFFFFFFC); complete(0);
      issue(32'h4);        complete(5);

      // flush while idle must block acceptance
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_addr  = 32'h8;
      flush     = 1'b1;
      @(negedge clk);
      chk("flush_idle_ready", req_ready, 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      flush     = 1'b0;
      repeat (3) @(negedge clk);
      chk("flush_idle_norsp", rsp_valid, 0);

      issue(32'h8); flush_after(0);
      issue(32'hC); flush_after(1);
      issue(32'h14); flush_after(3);

      // flush together with rsp_ready counts as consumed
      issue(32'h10);
      t = 0;
      while (!rsp_valid && t < 10) begin
         @(negedge clk);
         t++;
      end
      chk("fr_seen_valid", rsp_valid, 1);
      @(posedge clk); #1;
      flush     = 1'b1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      flush     = 1'b0;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("fr_valid", rsp_valid, 0);
      chk("fr_ready", req_ready, 1);

      // reset mid-fetch drops the response and clears outputs
      issue(32'h20);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_ready", req_ready, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      if (q.size() > 0) void'(q.pop_back());
      @(negedge clk);
      chk("rst_mid_valid", rsp_valid, 0);
      chk("rst_mid_instr", rsp_instr, 0);
      chk("rst_mid_err", {30'd0, rsp_err}, 0);
      repeat (3) @(negedge clk);
      chk("rst_mid_norsp", rsp_valid, 0);
      issue(32'h0); complete(0);

`ifdef IM_LOAD_PORT_EN
      load(32'h10, 32'h12345678);
      {mm[16], mm[17], mm[18], mm[19]} = 32'h12345678;
      issue(32'h10); complete(0);
      load(32'h11, 32'hDEADBEEF);
      issue(32'h10); complete(0);
      @(posedge clk); #1;
      load_valid = 1'b1;
      load_addr  = 32'h7F;
      req_valid  = 1'b1;
      @(negedge clk);
      chk("load_blocks_ready", req_ready, 0);
      @(posedge clk); #1;
      load_valid = 1'b0;
      req_valid  = 1'b0;
`endif

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) a = $urandom;
         else a = 32'($urandom_range(0, MB + 4));
         issue(a);
         if ($urandom_range(0, 4) == 0) flush_after($urandom_range(0, 3));
         else complete($urandom_range(0, 3));
      end

      repeat (4) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 128, meaning instruction storage size in bytes (multiple of 4, 8..65536).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to rsp_valid (legal 1..4).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  fetch request present.
REQ-006 SHALL have port req_ready  output  1  block accepts request this cycle.
REQ-007 SHALL have port req_addr  input  32  byte address of instruction.
REQ-008 SHALL have port flush  input  1  cancel any in-flight fetch.
REQ-009 SHALL have port rsp_valid  output  1  response present.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes response.
REQ-011 SHALL have port rsp_instr  output  32  fetched instruction word.
REQ-012 SHALL have port rsp_err  output  2  bit0 misaligned, bit1 out-of-range.

Function
REQ-013 SHALL implement states IDLE, WAIT, RESP.
REQ-014 req_ready SHALL be 1 only in IDLE with flush=0 (and no load, REQ-029).
REQ-015 Acceptance = req_valid & req_ready at an edge; address latched; next state WAIT with counter LATENCY-1, or RESP directly when LATENCY=1.
REQ-016 WAIT SHALL decrement counter each cycle; on counter reaching 1 next state RESP, so rsp_valid rises exactly LATENCY cycles after acceptance edge.
REQ-017 In RESP rsp_valid=1 and rsp_instr/rsp_err SHALL stay stable until rsp_ready=1; then next state IDLE.
REQ-018 A request presented in the same cycle as rsp_ready handshake SHALL NOT be accepted (req_ready=0 in RESP); throughput one fetch per LATENCY+1 cycles.
REQ-019 Word SHALL be big-endian: rsp_instr = {M[a], M[a+1], M[a+2], M[a+3]}.
REQ-020 Data SHALL be sampled from storage on the cycle rsp_valid first rises.
REQ-021 addr[1:0]!=0 SHALL set rsp_err[0]; addr+3 >= MEM_BYTES (32-bit compare, no wrap) SHALL set rsp_err[1]; either error forces rsp_instr=0; both bits may be set.
REQ-022 flush=1 in WAIT or RESP SHALL return to IDLE next edge with no response; rsp_valid deasserts next cycle; flush in IDLE SHALL block acceptance.
REQ-023 flush and rsp_ready both 1 in RESP SHALL count as consumed, then IDLE.

Reset
REQ-024 rst_n=0 at an edge SHALL force IDLE, counter 0, rsp_valid=0, rsp_instr=0, rsp_err=0, from any state including mid-fetch; no response is produced for the aborted fetch.
REQ-025 Reset SHALL NOT clear storage contents.
REQ-026 While rst_n=0, req_ready SHALL be 0.

Configuration
REQ-027 Macro IM_LOAD_PORT_EN SHALL add inputs load_valid (1), load_addr (32), load_data (32).
REQ-028 With macro: load_valid=1 at an edge SHALL write load_data big-endian to word at load_addr; misaligned or out-of-range loads are silently dropped.
REQ-029 With macro: load_valid=1 SHALL force req_ready=0; loads are legal in any state, and a fetch in flight to the loaded word returns the new data if loaded before REQ-020 sampling.
REQ-030 Without macro: load ports absent, storage read-only, filled only by $readmemh in simulation.

Structure
REQ-031 Package instr_fetch_pkg SHALL hold the state enum, error bit index constants ERR_MISALIGN=0, ERR_RANGE=1, and LATENCY_MIN/MAX.
REQ-032 Storage SHALL be sub-module im_byte_array (byte array, 4-byte combinational read port, optional word write port).
REQ-033 Top SHALL hold FSM, counter, address latch, error checks, response registers.

Verification
REQ-034 LATENCY=2, M[0..3]=8C,01,00,04; req addr 0 accepted at edge T -> rsp_valid at T+2, rsp_instr=0x8C010004, rsp_err=0.
REQ-035 req addr 0x6 -> rsp_err=2'b01, rsp_instr=0; req addr 0x7E (MEM_BYTES=128) -> rsp_err=2'b11; addr 0x7C -> rsp_err=0.
REQ-036 rsp_ready held 0 for 5 cycles -> rsp_valid and data stable, req_ready=0 throughout; release -> IDLE next cycle.
REQ-037 flush one cycle after acceptance (LATENCY=3) -> no rsp_valid ever; req_ready=1 two cycles later.
REQ-038 rst_n=0 during WAIT -> next cycle all outputs 0, state IDLE; storage unchanged on re-fetch.
REQ-039 IM_LOAD_PORT_EN: load 0x12345678 to addr 0x10 then fetch 0x10 -> rsp_instr=0x12345678; load addr 0x11 -> storage unchanged.
